pipe_intc: RTL and testbench
============================

Name: pipe_intc

Overview:
Interrupt controller that sits directly upstream of the pipelined CPU and drives its intr/inta handshake. It latches rising edges on NSRC external request lines into a pending register and filters them through a software-written enable register. It picks the lowest-numbered eligible source, asserts intr, and holds the source id stable for the CPU's cause register. After inta, the source stays in service until end-of-interrupt (eoi).

Parameters:
NSRC, 8, number of interrupt sources (2..32)
IDW, 3, width of source id; must satisfy 2**IDW >= NSRC

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
irq  input  NSRC  external request lines, rising-edge sensitive
ien_we  input  1  write strobe for the enable register
ien_wdata  input  NSRC  new enable-register value
intr  output  1  interrupt request to the CPU
inta  input  1  CPU acknowledge, one-cycle pulse
eoi  input  1  end-of-interrupt from the handler, one-cycle pulse
irq_id  output  IDW  id of the requested or in-service source
in_service  output  1  high from accepted inta until eoi
pending  output  NSRC  pending register, for software readback
ien  output  NSRC  enable register, for readback

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) clears the following:
  - state goes to IDLE.
  - intr=0, in_service=0, irq_id=0.
  - pending=0, ien=0.
  - Edge-detect history irq_q=0, so a line held high through reset release counts as an edge on the first cycle after reset.
  - Reset asserted mid-handshake, in any state, aborts the handshake immediately. No eoi is needed afterwards.
- Edge capture and pending register:
  - Every cycle, irq_q <= irq.
  - rise = irq & ~irq_q.
  - pending[i] is set on rise[i].
  - pending[i] is cleared only by an accepted inta with irq_id==i.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Enable register: on ien_we, ien <= ien_wdata, effective the next cycle. Masking never clears pending; it only hides it.
- eligible = pending & ien. Selection is fixed priority: the lowest index wins.
- State machine (registered outputs):
  - IDLE:
    - If eligible != 0: irq_id <= lowest eligible index, intr <= 1, go to REQ.
    - Otherwise stay in IDLE.
  - REQ: intr held high and irq_id held stable.
    - If inta=1: clear pending[irq_id], intr <= 0, in_service <= 1, go to SERVICE.
    - Else if eligible[irq_id]==0 (the request was masked by an ien write): intr <= 0, go to IDLE. Re-arbitration happens from IDLE on the next cycle.
    - A higher-priority source arriving during REQ does not preempt. irq_id never changes while intr=1.
  - SERVICE:
    - If eoi=1: in_service <= 0, go to IDLE. Arbitration of any still-pending sources starts on the following cycle.
    - Edges arriving during SERVICE, including on the same source, are recorded in pending.
- Ignored inputs:
  - inta in IDLE or SERVICE is ignored.
  - eoi in IDLE or REQ is ignored.
  - inta and eoi in the same cycle: only the one legal for the current state takes effect.
- Latency:
  - irq rises before rising edge k, so pending is set at edge k.
  - intr is high after edge k+1 (2-cycle irq-to-intr).
  - intr drops on the edge that samples inta=1.
  - The minimum gap from eoi to the next intr is 2 cycles.
- Outputs pending and ien are the register values. irq_id in IDLE retains its last value.

Optional Feature:
INTC_SYNC_EN
- Defined: irq passes through a 2-flop synchronizer (reset to 0) before edge detection. irq-to-intr latency becomes 4 cycles. Use this for asynchronous sources.
- Undefined: irq is used directly, and sources must be synchronous to clock. Latency is 2 cycles.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, ien_we with wdata=8'hFF, pulse irq[5] for 1 cycle -> pending=8'h20 after 1 cycle; intr=1, irq_id=5 after 2 cycles; inta pulse -> intr=0, in_service=1, pending=0; eoi -> in_service=0, state IDLE.
- ien=8'hFF, irq[6] and irq[2] rise in the same cycle -> irq_id=2 first. After inta+eoi, intr reasserts with irq_id=6, 2 cycles after eoi.
- ien=8'h00, irq[3] rises -> pending=8'h08, intr stays 0. Write ien=8'h08 -> intr=1, irq_id=3 two cycles after the write.
- In REQ for id 4 (no inta), write ien=8'h00 -> intr drops the next cycle, pending[4] stays 1, and no inta is required.
- Hold irq[1] high across reset release with ien=8'h02 -> treated as an edge; intr=1, irq_id=1. A new rise on irq[1] in the same cycle as the accepting inta leaves pending[1]=1. Assert reset during SERVICE -> in_service=0, pending=0, no eoi needed.

Source files
------------

// File: rtl/pipe_intc.sv
// ----------------------------------------------------------------------------
// pipe_intc -- interrupt controller in front of the pipelined CPU.
//
// Captures rising edges on NSRC request lines into a pending register and
// filters them through a software-written enable register. The lowest-numbered
// eligible source is presented to the CPU on intr_o/irq_id_o. It stays there
// until the CPU acknowledges with inta_i. The source is then in service until
// the handler signals eoi_i.
//
// Optional build macro: INTC_SYNC_EN
//   defined   -> irq_i passes through a 2-flop synchronizer before edge
//                detection (for asynchronous sources; irq-to-intr = 4 cycles)
//   undefined -> irq_i must be synchronous to clock_i (irq-to-intr = 2 cycles)
//
// Ports:
//   clock_i       system clock, all state updates on the rising edge
//   reset_i       synchronous active-high reset
//   irq_i         external request lines, rising-edge sensitive
//   ien_we_i      write strobe for the enable register
//   ien_wdata_i   new enable-register value
//   intr_o        interrupt request to the CPU
//   inta_i        CPU acknowledge, one-cycle pulse
//   eoi_i         end-of-interrupt from the handler, one-cycle pulse
//   irq_id_o      id of the requested / in-service source
//   in_service_o  high from accepted inta until eoi
//   pending_o     pending register readback
//   ien_o         enable register readback
//
// Parameters: NSRC (2..32) sources, IDW id width with 2**IDW >= NSRC.
// ----------------------------------------------------------------------------
module pipe_intc #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [NSRC-1:0] irq_i,
    input  logic            ien_we_i,
    input  logic [NSRC-1:0] ien_wdata_i,
    output logic            intr_o,
    input  logic            inta_i,
    input  logic            eoi_i,
    output logic [IDW-1:0]  irq_id_o,
    output logic            in_service_o,
    output logic [NSRC-1:0] pending_o,
    output logic [NSRC-1:0] ien_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            intr_q, intr_d;
    logic            in_service_q, in_service_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] ien_q, ien_d;
    logic [NSRC-1:0] irq_q;

    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] id_onehot;
    logic [NSRC-1:0] clr_mask;
    logic [IDW-1:0]  sel_id;
    logic            cur_eligible;

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_src = sync2_q;
`else
    assign irq_src = irq_i;
`endif

    // History is cleared by reset, so a line held high through reset release
    // is seen as a fresh edge on the first cycle afterwards.
    assign rise     = irq_src & ~irq_q;
    assign eligible = pending_q & ien_q;

    // One-hot decode of the current id; avoids indexing past NSRC when
    // 2**IDW > NSRC.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_onehot
            assign id_onehot[gi] = (irq_id_q == IDW'(gi));
        end
    endgenerate

    assign cur_eligible = |(eligible & id_onehot);

    // Fixed priority: scan from the top so the lowest index is written last.
    always_comb begin
        sel_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        intr_d       = intr_q;
        in_service_d = in_service_q;
        irq_id_d     = irq_id_q;
        clr_mask     = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    irq_id_d = sel_id;
                    intr_d   = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // irq_id is frozen while intr is high; a higher-priority
                // arrival waits for the next arbitration from IDLE.
                if (inta_i) begin
                    clr_mask     = id_onehot;
                    intr_d       = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end else if (!cur_eligible) begin
                    // Request withdrawn by an enable write; no inta expected.
                    intr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_i) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                intr_d       = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // Set has priority over clear so a new edge during the acknowledge is kept.
    assign pending_d = (pending_q & ~clr_mask) | rise;
    assign ien_d     = ien_we_i ? ien_wdata_i : ien_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            intr_q       <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
            pending_q    <= '0;
            ien_q        <= '0;
            irq_q        <= '0;
        end else begin
            state_q      <= state_d;
            intr_q       <= intr_d;
            in_service_q <= in_service_d;
            irq_id_q     <= irq_id_d;
            pending_q    <= pending_d;
            ien_q        <= ien_d;
            irq_q        <= irq_src;
        end
    end

    assign intr_o       = intr_q;
    assign in_service_o = in_service_q;
    assign irq_id_o     = irq_id_q;
    assign pending_o    = pending_q;
    assign ien_o        = ien_q;

endmodule

// File: tb/tb_pipe_intc.sv
// ----------------------------------------------------------------------------
// tb_pipe_intc -- scoreboard bench for pipe_intc (default build, 2-cycle
// irq-to-intr). Stimulus pushes expected output snapshots, tagged with the
// cycle they must appear in, into a queue. A separate monitor on the falling
// edge pops and compares every entry due in that cycle.
// ----------------------------------------------------------------------------
module tb_pipe_intc;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic       ien_we;
    logic [7:0] ien_wdata;
    logic       intr;
    logic       inta;
    logic       eoi;
    logic [2:0] irq_id;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] ien;

    pipe_intc #(.NSRC(8), .IDW(3)) dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .irq_i        (irq),
        .ien_we_i     (ien_we),
        .ien_wdata_i  (ien_wdata),
        .intr_o       (intr),
        .inta_i       (inta),
        .eoi_i        (eoi),
        .irq_id_o     (irq_id),
        .in_service_o (in_service),
        .pending_o    (pending),
        .ien_o        (ien)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic       intr;
        logic [2:0] id;
        logic       insvc;
        logic [7:0] pend;
        logic [7:0] ien;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Expect a snapshot dly edges after the current one.
    task automatic chk(input int dly, input string name, input logic e_intr,
                       input logic [2:0] e_id, input logic e_insvc,
                       input logic [7:0] e_pend, input logic [7:0] e_ien);
        exp_t e;
        e.at = cyc + dly; e.name = name; e.intr = e_intr; e.id = e_id;
        e.insvc = e_insvc; e.pend = e_pend; e.ien = e_ien;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every snapshot that falls due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (e.at < cyc) begin
                bad++;
                $display("FAIL %s: snapshot missed (due cycle %0d, now %0d)", e.name, e.at, cyc);
            end else if (intr !== e.intr || irq_id !== e.id || in_service !== e.insvc ||
                         pending !== e.pend || ien !== e.ien) begin
                bad++;
                $display("FAIL %s: got intr=%b id=%0d insvc=%b pend=%h ien=%h, want intr=%b id=%0d insvc=%b pend=%h ien=%h",
                         e.name, intr, irq_id, in_service, pending, ien,
                         e.intr, e.id, e.insvc, e.pend, e.ien);
            end else begin
                $display("ok   %s: intr=%b id=%0d insvc=%b pend=%h ien=%h",
                         e.name, intr, irq_id, in_service, pending, ien);
            end
        end
    end

    initial begin
        reset = 1'b1; irq = '0; ien_we = 1'b0; ien_wdata = '0; inta = 1'b0; eoi = 1'b0;
        tick(2);
        chk(0, "reset", 0, 0, 0, 8'h00, 8'h00);

        // 1: single source 5, full handshake
        reset = 1'b0; ien_we = 1'b1; ien_wdata = 8'hFF;
        tick(1);
        ien_we = 1'b0;
        chk(0, "ien_ff", 0, 0, 0, 8'h00, 8'hFF);
        irq = 8'h20;
        chk(1, "pend5", 0, 0, 0, 8'h20, 8'hFF);
        chk(2, "intr5", 1, 5, 0, 8'h20, 8'hFF);
        tick(1);
        irq = 8'h00;
        tick(1);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk(0, "ack5", 0, 5, 1, 8'h00, 8'hFF);
        tick(1);
        chk(0, "svc5", 0, 5, 1, 8'h00, 8'hFF);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        chk(0, "eoi5", 0, 5, 0, 8'h00, 8'hFF);
        tick(1);
        chk(0, "idle5", 0, 5, 0, 8'h00, 8'hFF);

        // 2: sources 6 and 2 together -> 2 first, then 6 two cycles after eoi
        irq = 8'h44;
        tick(1);
        irq = 8'h00;
        chk(0, "pend62", 0, 5, 0, 8'h44, 8'hFF);
        tick(1);
        chk(0, "pick2", 1, 2, 0, 8'h44, 8'hFF);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk(0, "ack2", 0, 2, 1, 8'h40, 8'hFF);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        chk(0, "eoi2", 0, 2, 0, 8'h40, 8'hFF);
        tick(1);
        chk(0, "pick6", 1, 6, 0, 8'h40, 8'hFF);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk(0, "ack6", 0, 6, 1, 8'h00, 8'hFF);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        chk(0, "eoi6", 0, 6, 0, 8'h00, 8'hFF);

        // 3: masked source 3 is held pending, released by an enable write
        ien_we = 1'b1; ien_wdata = 8'h00;
        tick(1);
        ien_we = 1'b0;
        irq = 8'h08;
        tick(1);
        irq = 8'h00;
        chk(0, "mask3", 0, 6, 0, 8'h08, 8'h00);
        tick(1);
        chk(0, "hold3", 0, 6, 0, 8'h08, 8'h00);
        ien_we = 1'b1; ien_wdata = 8'h08;
        tick(1);
        ien_we = 1'b0;
        chk(0, "ien3", 0, 6, 0, 8'h08, 8'h08);
        tick(1);
        chk(0, "unmask3", 1, 3, 0, 8'h08, 8'h08);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk(0, "ack3", 0, 3, 1, 8'h00, 8'h08);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        chk(0, "eoi3", 0, 3, 0, 8'h00, 8'h08);

        // 4: request for 4 withdrawn by masking; inta in IDLE ignored
        ien_we = 1'b1; ien_wdata = 8'hFF;
        tick(1);
        ien_we = 1'b0;
        irq = 8'h10;
        tick(1);
        irq = 8'h00;
        tick(1);
        chk(0, "req4", 1, 4, 0, 8'h10, 8'hFF);
        ien_we = 1'b1; ien_wdata = 8'h00;
        tick(1);
        ien_we = 1'b0;
        chk(0, "mask4", 1, 4, 0, 8'h10, 8'h00);
        tick(1);
        chk(0, "drop4", 0, 4, 0, 8'h10, 8'h00);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk(0, "inta_idle", 0, 4, 0, 8'h10, 8'h00);

        // 5: irq[1] held through reset release; re-rise on the inta edge;
        //    reset during SERVICE
        reset = 1'b1; irq = 8'h02;
        tick(2);
        chk(0, "reset2", 0, 0, 0, 8'h00, 8'h00);
        reset = 1'b0; ien_we = 1'b1; ien_wdata = 8'h02;
        tick(1);
        ien_we = 1'b0;
        chk(0, "hold1", 0, 0, 0, 8'h02, 8'h02);
        tick(1);
        chk(0, "req1", 1, 1, 0, 8'h02, 8'h02);
        irq = 8'h00;
        tick(1);
        chk(0, "wait1", 1, 1, 0, 8'h02, 8'h02);
        irq = 8'h02; inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk(0, "ack1_set", 0, 1, 1, 8'h02, 8'h02);
        reset = 1'b1; irq = 8'h00;
        tick(1);
        reset = 1'b0;
        chk(0, "rst_svc", 0, 0, 0, 8'h00, 8'h00);
        tick(1);
        chk(0, "post_rst", 0, 0, 0, 8'h00, 8'h00);

        tick(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d snapshots left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
